// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: address-width derivation and parameter legality.
// Latency: none (elaboration-time constant functions only).
// Backpressure: not applicable.
package fifo_pkg;

    // Number of address bits for a power-of-two depth (log2 rounded up).
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_ok(input int width, input int depth,
                                     input int af_level, input int ae_level);
        bit ok;
        ok = 1'b1;
        if (width < 1)                               ok = 1'b0;
        if (depth < 2)                               ok = 1'b0;
        if ((depth & (depth - 1)) != 0)              ok = 1'b0;
        if (af_level < 1 || af_level > depth)        ok = 1'b0;
        if (ae_level < 0 || ae_level > depth - 1)    ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO: write port, read port, status and error flags.
// Latency: not applicable (wires only).
// Backpressure: producer watches full/overflow, consumer watches empty/underflow.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = log2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port with registered output.
// Latency: read data valid one cycle after re; write visible to a read issued the following cycle.
// Backpressure: none; caller guarantees addresses are legal.
module fifo_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register loads only on an accepted read, otherwise holds the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered read, occupancy count, threshold flags and sticky errors.
// Latency: read data one cycle after rd_en; a write is readable from the next cycle; flags update the edge an op is accepted.
// Backpressure: writes rejected when full (unless a read frees a slot), reads rejected when empty; rejections set sticky flags.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    fifo_sync_param_if.slave  bus
);

    localparam int AW = log2(DEPTH);
    localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic [AW:0] count_q;
    logic        full_q, empty_q, af_q, ae_q;
    logic        ovf_q, unf_q, rd_valid_q;
    logic        rd_acc, wr_acc;

    // A read is only taken from stored data; a write into a full FIFO rides on a same-cycle read.
    assign rd_acc = bus.rd_en & ~empty_q;
    assign wr_acc = bus.wr_en & (~full_q | rd_acc);

    // Next pointer values so every flag reflects this edge's accepted operations with no lag.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_acc) wr_ptr_nxt = wr_ptr + (AW+1)'(1);
        if (rd_acc) rd_ptr_nxt = rd_ptr + (AW+1)'(1);
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    // Pointers, occupancy, status and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count_q    <= count_nxt;
            full_q     <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                          (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
            empty_q    <= (wr_ptr_nxt == rd_ptr_nxt);
            af_q       <= (count_nxt >= AF_L);
            ae_q       <= (count_nxt <= AE_L);
            // A new rejection in the clearing cycle keeps the flag set.
            ovf_q      <= (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.clr_err);
            unf_q      <= (bus.rd_en & ~rd_acc) | (unf_q & ~bus.clr_err);
            rd_valid_q <= rd_acc;
        end
    end

    fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed scenarios plus random traffic against a queue-based model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: model decides acceptance from its own occupancy.
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, flags from plain arithmetic on its size.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rd_data;
    bit               m_rd_valid, m_ovf, m_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 0;
        m_ovf      = 0;
        m_unf      = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit clr);
        bit racc, wacc;
        racc = rd && (q.size() != 0);
        wacc = wr && ((q.size() != DEPTH) || racc);
        m_ovf = (wr && !wacc) || (m_ovf && !clr);
        m_unf = (rd && !racc) || (m_unf && !clr);
        m_rd_valid = racc;
        if (racc) m_rd_data = q.pop_front();
        if (wacc) q.push_back(d);
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = q.size();
        check_eq({tag, ".count"},    32'(bus.count), 32'(n));
        check_eq({tag, ".full"},     32'(bus.full), 32'(n == DEPTH));
        check_eq({tag, ".empty"},    32'(bus.empty), 32'(n == 0));
        check_eq({tag, ".afull"},    32'(bus.almost_full), 32'(n >= AF));
        check_eq({tag, ".aempty"},   32'(bus.almost_empty), 32'(n <= AE));
        check_eq({tag, ".ovf"},      32'(bus.overflow), 32'(m_ovf));
        check_eq({tag, ".unf"},      32'(bus.underflow), 32'(m_unf));
        check_eq({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rd_valid));
        check_eq({tag, ".rd_data"},  32'(bus.rd_data), 32'(m_rd_data));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".count"},    32'(bus.count), 0);
        check_eq({tag, ".full"},     32'(bus.full), 0);
        check_eq({tag, ".empty"},    32'(bus.empty), 1);
        check_eq({tag, ".afull"},    32'(bus.almost_full), 0);
        check_eq({tag, ".aempty"},   32'(bus.almost_empty), 1);
        check_eq({tag, ".ovf"},      32'(bus.overflow), 0);
        check_eq({tag, ".unf"},      32'(bus.underflow), 0);
        check_eq({tag, ".rd_valid"}, 32'(bus.rd_valid), 0);
        check_eq({tag, ".rd_data"},  32'(bus.rd_data), 0);
    endtask

    // One clock of stimulus; called and returns just after a falling edge.
    task automatic step(input string tag, input bit wr, input logic [WIDTH-1:0] d,
                        input bit rd, input bit clr);
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        bus.clr_err = clr;
        @(posedge clk);
        model_edge(wr, d, rd, clr);
        #1;
        check_outputs(tag);
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        reset       = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill with 0x01..0x08; almost_full after the 6th, full after the 8th.
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 6) check_eq("afull_at_6", 32'(bus.almost_full), 1);
        end
        check_eq("full_at_8", 32'(bus.full), 1);
        check_eq("count_at_8", 32'(bus.count), 8);

        // Rejected 9th write: overflow, contents untouched.
        step("wr_full", 1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("ovf_9th", 32'(bus.overflow), 1);

        // Drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("drain_order", 32'(bus.rd_data), 32'(i));
        end
        step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("unf_set", 32'(bus.underflow), 1);
        check_eq("unf_no_valid", 32'(bus.rd_valid), 0);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write+read while full.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'hA5, 1'b1, 1'b0);
        check_eq("full_wr_rd.oldest", 32'(bus.rd_data), 32'h10);
        check_eq("full_wr_rd.count", 32'(bus.count), 8);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous write+read while empty: no fall-through.
        step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        step("empty_wr_rd", 1'b1, 8'h5A, 1'b1, 1'b0);
        check_eq("empty_wr_rd.count", 32'(bus.count), 1);
        check_eq("empty_wr_rd.unf", 32'(bus.underflow), 1);

        // 20 back-to-back pairs with one word primed; pointers wrap.
        for (int i = 0; i < 20; i++) begin
            step("stream", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check_eq("stream.count", 32'(bus.count), 1);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        // Drain, then build up count=5 and pull reset between edges.
        for (int i = 0; i < DEPTH + 1; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("prime5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        check_eq("count_5", 32'(bus.count), 5);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Clear and set in the same cycle: set wins; then a plain clear.
        step("clr_vs_set", 1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("clr_vs_set.unf", 32'(bus.underflow), 1);
        step("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("clr_only.unf", 32'(bus.underflow), 0);
        step("post_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("post_rd.data", 32'(bus.rd_data), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
